writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 119 +++++++++++
 tb/tb_writeback_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Register-file writeback queue: merges ALU and LSU write requests into one
// in-order FIFO that drains one write per cycle and flags pending-write hazards.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [3:0]                 alu_sel,
  input  logic [31:0]                alu_data,
  output logic                       alu_ready,
  input  logic                       lsu_valid,
  input  logic [3:0]                 lsu_sel,
  input  logic [31:0]                lsu_data,
  output logic                       lsu_ready,
  output logic                       reg_write_enable,
  output logic [3:0]                 write_reg_sel,
  output logic [31:0]                write_reg_data,
  input  logic [3:0]                 query_sel1,
  input  logic [3:0]                 query_sel2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem_sel_q  [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic [3:0]    push_sel_s;
  logic [31:0]   push_data_s;

  // Handshake, pointer and occupancy next-state; reset masks every handshake.
  always_comb begin
    full_s      = (cnt_q == CW'(DEPTH));
    lsu_ready   = !full_s && !reset;
    alu_ready   = !full_s && !lsu_valid && !reset;
    push_s      = 1'b0;
    push_sel_s  = 4'd0;
    push_data_s = 32'd0;
    if (lsu_valid && lsu_ready) begin
      push_s      = 1'b1;
      push_sel_s  = lsu_sel;
      push_data_s = lsu_data;
    end else if (alu_valid && alu_ready) begin
      push_s      = 1'b1;
      push_sel_s  = alu_sel;
      push_data_s = alu_data;
    end else begin
      push_s      = 1'b0;
    end
    pop_s    = (cnt_q != {CW{1'b0}}) && !reset;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d    = cnt_q + CW'(push_s) - CW'(pop_s);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_sel_q[wr_ptr_q]  <= push_sel_s;
      mem_data_q[wr_ptr_q] <= push_data_s;
    end
  end

  // Register-file port and status outputs, all forced idle while reset is high.
  always_comb begin
    reg_write_enable = pop_s;
    write_reg_sel    = pop_s ? mem_sel_q[rd_ptr_q]  : 4'd0;
    write_reg_data   = pop_s ? mem_data_q[rd_ptr_q] : 32'd0;
    count            = reset ? {CW{1'b0}} : cnt_q;
    full             = full_s && !reset;
    empty            = (cnt_q == {CW{1'b0}}) || reset;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    logic [AW-1:0] off_s;
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    off_s   = {AW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off_s = AW'(i) - rd_ptr_q;
      if (({1'b0, off_s} < cnt_q) && !reset) begin
        if (mem_sel_q[i] == query_sel1) hazard1 = 1'b1;
        else                            hazard1 = hazard1;
        if (mem_sel_q[i] == query_sel2) hazard2 = 1'b1;
        else                            hazard2 = hazard2;
      end else begin
        hazard1 = hazard1;
        hazard2 = hazard2;
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: queue-level reference model compared every cycle,
// directed literal scenarios, then randomized traffic with sporadic resets.
module tb_writeback_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [3:0]  alu_sel, lsu_sel, query_sel1, query_sel2, write_reg_sel;
  logic [31:0] alu_data, lsu_data, write_reg_data;
  logic        reg_write_enable, hazard1, hazard2, full, empty;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed { logic [3:0] sel; logic [31:0] data; } entry_t;
  entry_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_sel(lsu_sel), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .reg_write_enable(reg_write_enable), .write_reg_sel(write_reg_sel),
    .write_reg_data(write_reg_data), .query_sel1(query_sel1), .query_sel2(query_sel2),
    .hazard1(hazard1), .hazard2(hazard2), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_has(input logic [3:0] s);
    foreach (q[i]) if (q[i].sel == s) return 1'b1;
    return 1'b0;
  endfunction

  // Compare every DUT output against what the queue model implies right now.
  task automatic settle();
    bit m_full;
    bit m_we;
    #2;
    m_full = (q.size() == DEPTH);
    m_we   = (q.size() > 0) && !reset;
    chk("lsu_ready", lsu_ready, !m_full && !reset);
    chk("alu_ready", alu_ready, !m_full && !lsu_valid && !reset);
    chk("reg_we", reg_write_enable, m_we);
    chk("wr_sel", write_reg_sel, m_we ? q[0].sel : 4'd0);
    chk("wr_data", write_reg_data, m_we ? q[0].data : 32'd0);
    chk("hazard1", hazard1, !reset && model_has(query_sel1));
    chk("hazard2", hazard2, !reset && model_has(query_sel2));
    chk("count", count, reset ? 0 : q.size());
    chk("full", full, !reset && m_full);
    chk("empty", empty, reset || (q.size() == 0));
  endtask

  // Clock edge: apply reset / pop / push rules to the model, then let outputs move.
  task automatic advance();
    entry_t e;
    bit m_full;
    @(posedge clk);
    m_full = (q.size() == DEPTH);
    if (reset) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (lsu_valid && !m_full) begin
        e.sel = lsu_sel; e.data = lsu_data; q.push_back(e);
      end else if (alu_valid && !m_full) begin
        e.sel = alu_sel; e.data = alu_data; q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_sel = 4'd0; lsu_sel = 4'd0; alu_data = 32'd0; lsu_data = 32'd0;
  endtask

  function automatic logic [3:0] pick_sel();
    return 4'($urandom_range(0, 3)) + ($urandom_range(0, 1) ? 4'd12 : 4'd0);
  endfunction

  initial begin
    reset = 1'b1; idle_inputs(); query_sel1 = 4'd3; query_sel2 = 4'd0;
    #1;
    settle();
    chk("rst_we_lit", reg_write_enable, 1'b0);
    chk("rst_lsurdy_lit", lsu_ready, 1'b0);
    chk("rst_empty_lit", empty, 1'b1);
    advance();
    settle(); advance();
    reset = 1'b0;
    settle();
    chk("post_rst_cnt_lit", count, 0);
    advance();

    // Single ALU push sel=3 data=0xAA.
    alu_valid = 1'b1; alu_sel = 4'd3; alu_data = 32'h0000_00AA;
    settle(); chk("s1_alurdy_lit", alu_ready, 1'b1); advance();
    idle_inputs();
    settle();
    chk("s1_we_lit", reg_write_enable, 1'b1);
    chk("s1_sel_lit", write_reg_sel, 4'd3);
    chk("s1_data_lit", write_reg_data, 32'hAA);
    chk("s1_haz_lit", hazard1, 1'b1);
    advance();
    settle(); chk("s1_empty_lit", empty, 1'b1); advance();

    // Both valid: LSU wins, ALU follows next cycle.
    alu_valid = 1'b1; alu_sel = 4'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_sel = 4'd2; lsu_data = 32'h22;
    settle();
    chk("s2_lsurdy_lit", lsu_ready, 1'b1);
    chk("s2_alurdy_lit", alu_ready, 1'b0);
    advance();
    lsu_valid = 1'b0;
    settle();
    chk("s2_alurdy2_lit", alu_ready, 1'b1);
    chk("s2_first_lit", write_reg_sel, 4'd2);
    advance();
    idle_inputs();
    settle();
    chk("s2_second_lit", write_reg_sel, 4'd1);
    chk("s2_second_d_lit", write_reg_data, 32'h11);
    advance();

    // Two writes to register 5 (PC-like 15 in query2), hazard held until drained.
    query_sel1 = 4'd5; query_sel2 = 4'd15;
    alu_valid = 1'b1; alu_sel = 4'd5; alu_data = 32'h10;
    settle(); advance();
    alu_data = 32'h20;
    settle();
    chk("s3_haz_a_lit", hazard1, 1'b1);
    chk("s3_d0_lit", write_reg_data, 32'h10);
    advance();
    idle_inputs();
    settle();
    chk("s3_haz_b_lit", hazard1, 1'b1);
    chk("s3_d1_lit", write_reg_data, 32'h20);
    advance();
    settle(); chk("s3_haz_off_lit", hazard1, 1'b0); advance();

    // Push every cycle: queue occupancy stays at one; sequence 1..6 drains in order.
    for (int k = 1; k <= 6; k++) begin
      lsu_valid = 1'b1; lsu_sel = 4'(k); lsu_data = 32'(k);
      settle();
      if (k > 1) chk("s4_order_lit", write_reg_data, 32'(k - 1));
      chk("s4_cnt_le1", count <= 1, 1'b1);
      advance();
    end
    idle_inputs();
    settle(); chk("s4_last_lit", write_reg_data, 32'h6); advance();
    settle(); chk("s4_cnt0_lit", count, 0); advance();

    // Reset with an entry queued: it must never be written.
    lsu_valid = 1'b1; lsu_sel = 4'd9; lsu_data = 32'hDEAD;
    settle(); advance();
    idle_inputs(); reset = 1'b1;
    settle(); chk("s5_we_lit", reg_write_enable, 1'b0); advance();
    reset = 1'b0;
    settle();
    chk("s5_cnt_lit", count, 0);
    chk("s5_we2_lit", reg_write_enable, 1'b0);
    advance();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 59) == 0);
      alu_valid  = $urandom_range(0, 1);
      lsu_valid  = ($urandom_range(0, 2) == 0);
      alu_sel    = pick_sel(); lsu_sel = pick_sel();
      alu_data   = $urandom;   lsu_data = $urandom;
      query_sel1 = pick_sel(); query_sel2 = pick_sel();
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
